// File: rtl/cc_refill_ctrl_if.sv
// cc_refill_ctrl_if: CPU request, comparator, tag/data SRAM, memory read and response signals of the refill controller
//   master: controller side (cc_refill_ctrl)
//   slave : environment side (CPU, comparator, SRAMs, memory)
interface cc_refill_ctrl_if #(
  parameter int TAG_W  = 17,
  parameter int IDX_W  = 9,
  parameter int OFF_W  = 6,
  parameter int BEAT_W = 128,
  parameter int BEATS  = 4
);
  localparam int LINE_W = BEAT_W * BEATS;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [31:0]       req_addr_i;
  logic              hs_pulse_o;
  logic              hit_i;
  logic              miss_i;
  logic [TAG_W-1:0]  tag_delayed_i;
  logic [IDX_W-1:0]  index_delayed_i;
  logic [OFF_W-1:0]  offset_delayed_i;
  logic [LINE_W-1:0] data_rdata_i;
  logic              tag_wren_o;
  logic [IDX_W-1:0]  tag_waddr_o;
  logic [TAG_W:0]    tag_wdata_o;
  logic              data_wren_o;
  logic [IDX_W-1:0]  data_waddr_o;
  logic [LINE_W-1:0] data_wdata_o;
  logic              mem_arvalid_o;
  logic              mem_arready_i;
  logic [31:0]       mem_araddr_o;
  logic [3:0]        mem_arlen_o;
  logic              mem_rvalid_i;
  logic              mem_rready_o;
  logic [BEAT_W-1:0] mem_rdata_i;
  logic              mem_rlast_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [63:0]       resp_data_o;
  logic              protocol_err_o;
  modport master (
    input  req_valid_i, req_addr_i, hit_i, miss_i, tag_delayed_i, index_delayed_i,
           offset_delayed_i, data_rdata_i, mem_arready_i, mem_rvalid_i, mem_rdata_i,
           mem_rlast_i, resp_ready_i,
    output req_ready_o, hs_pulse_o, tag_wren_o, tag_waddr_o, tag_wdata_o, data_wren_o,
           data_waddr_o, data_wdata_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o,
           mem_rready_o, resp_valid_o, resp_data_o, protocol_err_o
  );
  modport slave (
    output req_valid_i, req_addr_i, hit_i, miss_i, tag_delayed_i, index_delayed_i,
           offset_delayed_i, data_rdata_i, mem_arready_i, mem_rvalid_i, mem_rdata_i,
           mem_rlast_i, resp_ready_i,
    input  req_ready_o, hs_pulse_o, tag_wren_o, tag_waddr_o, tag_wdata_o, data_wren_o,
           data_waddr_o, data_wdata_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o,
           mem_rready_o, resp_valid_o, resp_data_o, protocol_err_o
  );
endinterface

// File: rtl/cc_refill_ctrl.sv
// cc_refill_ctrl: cache read sequencer -- lookup, hit response or line refill from memory, then respond
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : cc_refill_ctrl_if.master (request, comparator, SRAM write, memory read, response)
module cc_refill_ctrl #(
  parameter int TAG_W  = 17,
  parameter int IDX_W  = 9,
  parameter int OFF_W  = 6,
  parameter int BEAT_W = 128,
  parameter int BEATS  = 4
) (
  input logic clk,
  input logic rst,
  cc_refill_ctrl_if.master bus
);
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CW = $clog2(BEATS);
  localparam int WW = OFF_W - 3;
  typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, FILL, RESP} state_t;
  state_t            state;
  logic [CW-1:0]     beat_cnt;
  logic [LINE_W-1:0] line_buf;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WW-1:0]     word_q;
  logic [63:0]       resp_q;
  logic              err_q;
  logic              is_hit;
  logic              last_beat;
  assign is_hit    = bus.hit_i & ~bus.miss_i;
  assign last_beat = beat_cnt == CW'(BEATS - 1);
  assign bus.req_ready_o    = state == IDLE;
  assign bus.hs_pulse_o     = bus.req_ready_o & bus.req_valid_i;
  assign bus.tag_wren_o     = state == FILL;
  assign bus.data_wren_o    = state == FILL;
  assign bus.tag_waddr_o    = idx_q;
  assign bus.data_waddr_o   = idx_q;
  assign bus.tag_wdata_o    = {state == FILL, tag_q};
  assign bus.data_wdata_o   = line_buf;
  assign bus.mem_arvalid_o  = state == AR;
  assign bus.mem_araddr_o   = {tag_q, idx_q, {OFF_W{1'b0}}};
  assign bus.mem_arlen_o    = 4'(BEATS - 1);
  assign bus.mem_rready_o   = state == R;
  assign bus.resp_valid_o   = state == RESP;
  assign bus.resp_data_o    = resp_q;
  assign bus.protocol_err_o = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      line_buf <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (bus.hs_pulse_o) state <= LOOKUP;
        LOOKUP: begin
          if (is_hit) begin
            resp_q <= bus.data_rdata_i[64*bus.offset_delayed_i[OFF_W-1:3] +: 64];
            state  <= RESP;
          end else begin
            // anything other than a clean hit or clean miss is flagged and refilled
            if (bus.hit_i == bus.miss_i) err_q <= 1'b1;
            tag_q  <= bus.tag_delayed_i;
            idx_q  <= bus.index_delayed_i;
            word_q <= bus.offset_delayed_i[OFF_W-1:3];
            state  <= AR;
          end
        end
        AR:     if (bus.mem_arready_i) state <= R;
        R:      if (bus.mem_rvalid_i) begin
          line_buf[BEAT_W*beat_cnt +: BEAT_W] <= bus.mem_rdata_i;
          beat_cnt <= beat_cnt + 1'b1;
          // the beat count, not rlast, ends the burst
          if (bus.mem_rlast_i != last_beat) err_q <= 1'b1;
          if (last_beat) state <= FILL;
        end
        FILL: begin
          resp_q <= line_buf[64*word_q +: 64];
          state  <= RESP;
        end
        RESP:   if (bus.resp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cc_refill_ctrl.sv
// tb_cc_refill_ctrl: directed self-checking bench for cc_refill_ctrl
module tb_cc_refill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int fails = 0;
  int wren_cnt = 0;
  cc_refill_ctrl_if bus ();
  cc_refill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.tag_wren_o || bus.data_wren_o) wren_cnt <= wren_cnt + 1;
  task automatic issue(input logic [31:0] a);
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i = a;
    #1;
    vecs++;
    if ({bus.hs_pulse_o, bus.req_ready_o} !== 2'b11) begin
      fails++;
      $display("FAIL handshake {hs_pulse,req_ready} got %b exp 11", {bus.hs_pulse_o, bus.req_ready_o});
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.tag_delayed_i = a[31:15];
    bus.index_delayed_i = a[14:6];
    bus.offset_delayed_i = a[5:0];
  endtask
  task automatic run_miss(input logic [31:0] a, input int ar_wait, input logic [7:0] gaps,
                          input int bad_last, input int resp_wait, input logic [31:0] base,
                          input logic exp_err, input logic neither);
    logic [127:0] b[4];
    logic [511:0] line;
    logic [63:0] w;
    for (int i = 0; i < 4; i++) b[i] = {4{base + 32'(i)}};
    line = {b[3], b[2], b[1], b[0]};
    w = line[64*a[5:3] +: 64];
    issue(a);
    bus.miss_i = ~neither;
    bus.hit_i = 1'b0;
    bus.mem_arready_i = 1'b0;
    bus.resp_ready_i = 1'b0;
    @(negedge clk);
    bus.miss_i = 1'b0;
    vecs++;
    if ({bus.mem_arvalid_o, bus.mem_araddr_o, bus.mem_arlen_o, bus.req_ready_o} !== {1'b1, a[31:6], 6'd0, 4'd3, 1'b0}) begin
      fails++;
      $display("FAIL ar_req {arvalid,araddr,arlen,req_ready} got %h exp %h",
               {bus.mem_arvalid_o, bus.mem_araddr_o, bus.mem_arlen_o, bus.req_ready_o}, {1'b1, a[31:6], 6'd0, 4'd3, 1'b0});
    end
    for (int k = 0; k < ar_wait; k++) begin
      @(negedge clk);
      vecs++;
      if ({bus.mem_arvalid_o, bus.mem_araddr_o, bus.req_ready_o} !== {1'b1, a[31:6], 6'd0, 1'b0}) begin
        fails++;
        $display("FAIL ar_stall cycle %0d araddr got %h exp %h", k, bus.mem_araddr_o, {a[31:6], 6'd0});
      end
    end
    bus.mem_arready_i = 1'b1;
    @(negedge clk);
    bus.mem_arready_i = 1'b0;
    vecs++;
    if ({bus.mem_rready_o, bus.mem_arvalid_o} !== 2'b10) begin
      fails++;
      $display("FAIL r_enter {rready,arvalid} got %b exp 10", {bus.mem_rready_o, bus.mem_arvalid_o});
    end
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[2*i +: 2]) @(negedge clk);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i = b[i];
      bus.mem_rlast_i = (i == 3) ^ (i == bad_last);
      @(negedge clk);
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rlast_i = 1'b0;
      if (i == bad_last) begin
        vecs++;
        if (bus.protocol_err_o !== 1'b1) begin
          fails++;
          $display("FAIL rlast_err beat %0d protocol_err got %b exp 1", i, bus.protocol_err_o);
        end
      end
    end
    vecs++;
    if ({bus.tag_wren_o, bus.data_wren_o, bus.tag_waddr_o, bus.data_waddr_o, bus.tag_wdata_o} !==
        {2'b11, a[14:6], a[14:6], 1'b1, a[31:15]}) begin
      fails++;
      $display("FAIL fill_ctl {twren,dwren,twaddr,dwaddr,twdata} got %h exp %h",
               {bus.tag_wren_o, bus.data_wren_o, bus.tag_waddr_o, bus.data_waddr_o, bus.tag_wdata_o},
               {2'b11, a[14:6], a[14:6], 1'b1, a[31:15]});
    end
    vecs++;
    if (bus.data_wdata_o !== line) begin
      fails++;
      $display("FAIL fill_data got %h exp %h", bus.data_wdata_o, line);
    end
    @(negedge clk);
    for (int k = 0; k <= resp_wait; k++) begin
      vecs++;
      if ({bus.resp_valid_o, bus.resp_data_o, bus.req_ready_o, bus.tag_wren_o} !== {1'b1, w, 2'b00}) begin
        fails++;
        $display("FAIL miss_resp cycle %0d data got %h exp %h valid %b", k, bus.resp_data_o, w, bus.resp_valid_o);
      end
      if (k < resp_wait) @(negedge clk);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    vecs++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.protocol_err_o} !== {2'b10, exp_err}) begin
      fails++;
      $display("FAIL miss_done {req_ready,resp_valid,err} got %b exp %b",
               {bus.req_ready_o, bus.resp_valid_o, bus.protocol_err_o}, {2'b10, exp_err});
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    vecs++;
    if ({bus.req_ready_o, bus.hs_pulse_o, bus.tag_wren_o, bus.data_wren_o, bus.mem_arvalid_o,
         bus.mem_rready_o, bus.resp_valid_o, bus.protocol_err_o} !== 8'b1000_0000) begin
      fails++;
      $display("FAIL reset_ctl got %b exp 10000000", {bus.req_ready_o, bus.hs_pulse_o, bus.tag_wren_o,
               bus.data_wren_o, bus.mem_arvalid_o, bus.mem_rready_o, bus.resp_valid_o, bus.protocol_err_o});
    end
    vecs++;
    if ({bus.tag_waddr_o, bus.tag_wdata_o, bus.data_wdata_o, bus.mem_araddr_o, bus.resp_data_o} !== '0) begin
      fails++;
      $display("FAIL reset_data nonzero: twdata %h araddr %h resp %h", bus.tag_wdata_o, bus.mem_araddr_o, bus.resp_data_o);
    end
    rst = 1'b0;
  endtask
  task automatic test_hit;
    logic [511:0] line;
    for (int k = 0; k < 8; k++) line[64*k +: 64] = {32'hA5A5_0000, 32'(k)};
    issue(32'h0001_8048);
    bus.hit_i = 1'b1;
    bus.data_rdata_i = line;
    vecs++;
    if (bus.resp_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL hit_early resp_valid got %b exp 0", bus.resp_valid_o);
    end
    @(negedge clk);
    bus.hit_i = 1'b0;
    bus.data_rdata_i = '0;
    vecs++;
    if ({bus.resp_valid_o, bus.resp_data_o, bus.mem_arvalid_o, bus.tag_wren_o} !== {1'b1, 64'hA5A5_0000_0000_0001, 2'b00}) begin
      fails++;
      $display("FAIL hit_resp data got %h exp a5a5000000000001 valid %b", bus.resp_data_o, bus.resp_valid_o);
    end
    bus.resp_ready_i = 1'b1;
    @(negedge clk);
    bus.resp_ready_i = 1'b0;
    vecs++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.protocol_err_o} !== 3'b100) begin
      fails++;
      $display("FAIL hit_done {req_ready,resp_valid,err} got %b exp 100", {bus.req_ready_o, bus.resp_valid_o, bus.protocol_err_o});
    end
  endtask
  task automatic test_rst_mid_burst;
    int w0;
    w0 = wren_cnt;
    issue(32'h0000_0280);
    bus.miss_i = 1'b1;
    @(negedge clk);
    bus.miss_i = 1'b0;
    bus.mem_arready_i = 1'b1;
    @(negedge clk);
    bus.mem_arready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i = {4{32'hDEAD_0000 + 32'(i)}};
      @(negedge clk);
    end
    bus.mem_rvalid_i = 1'b0;
    rst = 1'b1;
    #1;
    vecs++;
    if ({bus.req_ready_o, bus.mem_rready_o, bus.tag_wren_o, bus.data_wren_o} !== 4'b1000) begin
      fails++;
      $display("FAIL rst_abort {req_ready,rready,twren,dwren} got %b exp 1000",
               {bus.req_ready_o, bus.mem_rready_o, bus.tag_wren_o, bus.data_wren_o});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({wren_cnt - w0, bus.data_wdata_o, bus.req_ready_o} !== {32'd0, 512'd0, 1'b1}) begin
      fails++;
      $display("FAIL rst_clean wren_cnt delta got %0d exp 0 req_ready %b", wren_cnt - w0, bus.req_ready_o);
    end
    run_miss(32'h0000_0280, 0, 8'h00, 4, 0, 32'h5A5A_0000, 1'b0, 1'b0);
  endtask
  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i = '0;
    bus.hit_i = 1'b0;
    bus.miss_i = 1'b0;
    bus.tag_delayed_i = '0;
    bus.index_delayed_i = '0;
    bus.offset_delayed_i = '0;
    bus.data_rdata_i = '0;
    bus.mem_arready_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;
    bus.mem_rlast_i = 1'b0;
    bus.resp_ready_i = 1'b0;
    test_reset;
    test_hit;
    run_miss(32'h0000_0140, 0, 8'h00, 4, 0, 32'hB0B0_0000, 1'b0, 1'b0);
    run_miss(32'h0000_0140, 4, 8'h00, 4, 2, 32'hC0C0_0000, 1'b0, 1'b0);
    run_miss(32'h1234_5678, 0, 8'b11_10_01_00, 4, 0, 32'hD0D0_0000, 1'b0, 1'b0);
    run_miss(32'h0000_0140, 0, 8'h00, 1, 0, 32'hE0E0_0000, 1'b1, 1'b0);
    test_rst_mid_burst;
    run_miss(32'h0001_8048, 0, 8'h00, 4, 0, 32'hF0F0_0000, 1'b1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
